hilo_div_ctrl: RTL and testbench
================================

# hilo_div_ctrl

Sequencer and HI/LO owner for the CPU's multiply/divide unit. It accepts DIV, DIVU, MTHI, MTLO, MFHI and MFLO requests from the execute stage. It runs divides in the background on an external multi-cycle unsigned divider core through a start/done handshake, and handles sign correction and divide-by-zero. It asserts `stall` only when the pipeline issues another HI/LO operation while a divide is still in flight.

## Interface
Parameters:
- `WIDTH`, default 32: operand, HI and LO width.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `op_valid`  in  1  request present this cycle.
- `op_code`  in  3  operation: 001 DIVU, 010 DIV, 011 MTHI, 100 MTLO, 101 MFHI, 110 MFLO; 000/111 are no-op.
- `op_a`  in  WIDTH  rs value: dividend, or MT source.
- `op_b`  in  WIDTH  rt value: divisor.
- `stall`  out  1  hold execute stage; the request is not accepted this cycle.
- `mf_data`  out  WIDTH  combinational HI (MFHI) or LO (MFLO); 0 otherwise.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.
- `dz_pulse`  out  1  one-cycle pulse when a divide by zero is accepted.
- `div_start`  out  1  one-cycle start strobe to the divider core.
- `div_dividend`, `div_divisor`  out  WIDTH  unsigned magnitudes to the core; stable from start until done.
- `div_done`  in  1  core result valid.
- `div_q`, `div_r`  in  WIDTH  core quotient and remainder.

## Operation
- States:
  - IDLE: no divide pending.
  - ISSUE: `div_start`=1.
  - WAIT: awaiting `div_done`.
  - FIX: sign correction and HI/LO write.
- Acceptance:
  - A request with a valid op code is accepted at a rising edge only in IDLE.
  - In ISSUE/WAIT/FIX, any valid op code asserts `stall` combinationally, and nothing is accepted.
  - The pipeline holds `op_*` while stalled.
  - No-op codes never stall.
- DIVU/DIV with `op_b`≠0, accepted in IDLE:
  - Register sign_q = a[31]^b[31] (DIV only) and sign_r = a[31] (DIV only).
  - Register the magnitudes |a| and |b| for DIV, or the raw a and b for DIVU, onto `div_dividend`/`div_divisor`.
  - Go to ISSUE.
- ISSUE: `div_start`=1 for exactly one cycle; go to WAIT. `div_done` is ignored in ISSUE.
- WAIT: on the edge sampling `div_done`=1, capture `div_q`/`div_r` and go to FIX.
- FIX: on the next edge, write LO = sign_q ? −q : q and HI = sign_r ? −r : r; go to IDLE.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of the magnitude path naturally and needs no special case.
- Divide by zero (`op_b`=0, DIV or DIVU), accepted in IDLE:
  - The core is not started.
  - At the accepting edge, LO=0xFFFFFFFF and HI=`op_a` (raw, unsigned), and `dz_pulse`=1 for the following cycle.
  - State stays IDLE.
- MTHI/MTLO in IDLE: `op_a` is written to `hi`/`lo` at the accepting edge.
- MFHI/MFLO in IDLE: `mf_data` = current `hi`/`lo` combinationally; no register update.
- `div_done` outside WAIT is ignored.

## Timing
- Reset values: `hi`=0, `lo`=0, `stall`=0, `div_start`=0, `div_dividend`=0, `div_divisor`=0, `dz_pulse`=0, `mf_data`=0, state IDLE.
- Reset mid-divide aborts immediately: state returns to IDLE, the pending result is discarded, and `div_start` drops asynchronously.
- Divide accepted at edge E0:
  - `div_start` is high during cycle E0→E1.
  - If the core raises `div_done` at sample edge Ed (Ed ≥ E2), HI/LO update at edge Ed+1.
  - The next HI/LO op is accepted at edge Ed+1 at the earliest; it sees `stall`=1 through cycle Ed→Ed+1.
  - Total controller overhead is 2 cycles beyond core latency.
- MT, MF and divide-by-zero complete in zero extra cycles, with no stall when in IDLE.
- `stall` is purely combinational: (state≠IDLE) & `op_valid` & (op_code ∈ 001..110).

## Test plan
- After reset, `hi`=`lo`=0. MTHI 0x12345678, then MFHI: `mf_data`=0x12345678 with no stall.
- DIVU 100/7 against a core model with 32-cycle latency:
  - `div_start` is a single pulse.
  - `div_dividend`=100 and `div_divisor`=7 held stable.
  - LO=14, HI=2 exactly one edge after `div_done`.
- DIV −7/2, i.e. 0xFFFFFFF9 / 2:
  - Core receives 7 and 2.
  - LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - Also run 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MFLO issued one cycle after DIV acceptance:
  - `stall`=1 for every cycle until the FIX edge.
  - After the FIX edge, `stall`=0 and `mf_data` equals the new quotient.
- DIVU 55/0:
  - No `div_start`.
  - LO=0xFFFFFFFF, HI=55 the next cycle.
  - `dz_pulse` lasts one cycle.
  - A back-to-back MFHI is not stalled.
- Assert `reset` while in WAIT:
  - `hi`/`lo` return to 0, state returns to IDLE, `stall` returns to 0.
  - A late `div_done` after reset leaves HI/LO unchanged.

Source files
------------

// File: rtl/hilo_div_if.sv
// Request/response bundle between the execute stage, the HI/LO sequencer and
// the external unsigned divider core.
interface hilo_div_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             stall;
    logic [WIDTH-1:0] mf_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz_pulse;
    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_done;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    modport slave (
        input  op_valid, op_code, op_a, op_b, div_done, div_q, div_r,
        output stall, mf_data, hi, lo, dz_pulse, div_start, div_dividend, div_divisor
    );

    modport master (
        output op_valid, op_code, op_a, op_b, div_done, div_q, div_r,
        input  stall, mf_data, hi, lo, dz_pulse, div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO owner and divide sequencer: runs signed/unsigned divides on an external
// unsigned core, applies sign correction and handles divide-by-zero.
module hilo_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
    hilo_div_if.slave bus
);
    localparam logic [2:0] OP_DIVU = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;
    localparam logic [2:0] OP_MFHI = 3'b101;
    localparam logic [2:0] OP_MFLO = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIX} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hi, r_lo, r_q, r_r;
    logic [WIDTH-1:0] r_dividend, r_divisor;
    logic             r_sign_q, r_sign_r, r_dz;
    logic             w_op_legal, w_idle, w_accept, w_is_div, w_is_sdiv, w_div_zero;
    logic             w_neg_a, w_neg_b;
    logic [WIDTH-1:0] w_mf_data;

    // Two's-complement negate when neg is set; used for both magnitude and sign fix.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

    assign w_op_legal = (bus.op_code != 3'b000) && (bus.op_code != 3'b111);
    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = w_idle && bus.op_valid && w_op_legal;
    assign w_is_sdiv  = (bus.op_code == OP_DIV);
    assign w_is_div   = (bus.op_code == OP_DIVU) || w_is_sdiv;
    assign w_div_zero = (bus.op_b == '0);
    assign w_neg_a    = w_is_sdiv && bus.op_a[WIDTH-1];
    assign w_neg_b    = w_is_sdiv && bus.op_b[WIDTH-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept && w_is_div && !w_div_zero) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (bus.div_done) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            r_dz <= w_accept && w_is_div && w_div_zero;
            if (w_accept) begin
                case (bus.op_code)
                    OP_DIVU, OP_DIV: begin
                        if (w_div_zero) begin
                            r_lo <= '1;
                            r_hi <= bus.op_a;
                        end else begin
                            r_sign_q   <= w_neg_a ^ w_neg_b;
                            r_sign_r   <= w_neg_a;
                            r_dividend <= apply_sign(bus.op_a, w_neg_a);
                            r_divisor  <= apply_sign(bus.op_b, w_neg_b);
                        end
                    end
                    OP_MTHI: r_hi <= bus.op_a;
                    OP_MTLO: r_lo <= bus.op_a;
                    default: ;
                endcase
            end
            if ((r_state == S_WAIT) && bus.div_done) begin
                r_q <= bus.div_q;
                r_r <= bus.div_r;
            end
            if (r_state == S_FIX) begin
                r_lo <= apply_sign(r_q, r_sign_q);
                r_hi <= apply_sign(r_r, r_sign_r);
            end
        end
    end

    // Move-from reads are only meaningful when the request can be accepted.
    always_comb begin
        w_mf_data = '0;
        if (w_idle && bus.op_valid) begin
            if (bus.op_code == OP_MFHI)      w_mf_data = r_hi;
            else if (bus.op_code == OP_MFLO) w_mf_data = r_lo;
        end
    end

    assign bus.stall        = !w_idle && bus.op_valid && w_op_legal;
    assign bus.mf_data      = w_mf_data;
    assign bus.hi           = r_hi;
    assign bus.lo           = r_lo;
    assign bus.dz_pulse     = r_dz;
    assign bus.div_start    = (r_state == S_ISSUE);
    assign bus.div_dividend = r_dividend;
    assign bus.div_divisor  = r_divisor;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl with a behavioural divider core and
// a reference model built from plain signed/unsigned arithmetic.
module tb_hilo_div_ctrl;
    localparam int W = 32;
    localparam logic [2:0] DIVU = 3'b001, DIV = 3'b010, MTHI = 3'b011,
                           MTLO = 3'b100, MFHI = 3'b101, MFLO = 3'b110;

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   core_lat = 32;

    always #5 clock = ~clock;

    hilo_div_if #(.WIDTH(W)) bus();
    hilo_div_ctrl #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    // Divider core: latches operands on start, answers core_lat edges later.
    initial begin : core_model
        logic [W-1:0] ca, cb;
        bus.div_done = 1'b0;
        bus.div_q    = '0;
        bus.div_r    = '0;
        forever begin
            @(posedge clock);
            if (bus.div_start === 1'b1) begin
                ca = bus.div_dividend;
                cb = bus.div_divisor;
                repeat (core_lat) @(posedge clock);
                #1;
                bus.div_done = 1'b1;
                bus.div_q    = (cb != 0) ? ca / cb : '1;
                bus.div_r    = (cb != 0) ? ca % cb : ca;
                @(posedge clock);
                #1;
                bus.div_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_valid = v;
        bus.op_code  = c;
        bus.op_a     = a;
        bus.op_b     = b;
    endtask

    // Architectural result of a divide, straight from the ISA rules.
    function automatic void ref_div(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] ehi, output logic [W-1:0] elo,
                                    output logic [W-1:0] edvd, output logic [W-1:0] edvs);
        edvd = '0;
        edvs = '0;
        if (b == 0) begin
            elo = '1;
            ehi = a;
        end else if (code == DIVU) begin
            elo = a / b;
            ehi = a % b;
            edvd = a;
            edvs = b;
        end else begin
            edvd = ($signed(a) < 0) ? -a : a;
            edvs = ($signed(b) < 0) ? -b : b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                elo = 32'h8000_0000;
                ehi = '0;
            end else begin
                elo = $signed(a) / $signed(b);
                ehi = $signed(a) % $signed(b);
            end
        end
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 3'b000, '0, '0);
        repeat (3) @(posedge clock);
        #1;
        tests++; if (bus.hi !== 0)           begin fails++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
        tests++; if (bus.lo !== 0)           begin fails++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
        tests++; if (bus.div_start !== 0)    begin fails++; $display("FAIL reset_start: got %b want 0", bus.div_start); end
        tests++; if (bus.div_dividend !== 0 || bus.div_divisor !== 0)
            begin fails++; $display("FAIL reset_operands: got %h/%h want 0/0", bus.div_dividend, bus.div_divisor); end
        tests++; if (bus.dz_pulse !== 0)     begin fails++; $display("FAIL reset_dz: got %b want 0", bus.dz_pulse); end
        tests++; if (bus.mf_data !== 0)      begin fails++; $display("FAIL reset_mf: got %h want 0", bus.mf_data); end
        reset = 1'b0;
        drive(1'b1, MFHI, '0, '0);
        #1;
        tests++; if (bus.stall !== 0 || bus.mf_data !== 0)
            begin fails++; $display("FAIL reset_idle: stall %b mf %h want 0/0", bus.stall, bus.mf_data); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] mhi, mlo, v;
        mhi = bus.hi;
        mlo = bus.lo;
        for (int i = 0; i < 8; i++) begin
            v = (i == 0) ? 32'h1234_5678 : $urandom;
            @(posedge clock); #1;
            drive(1'b1, (i % 2 == 0) ? MTHI : MTLO, v, $urandom);
            #1;
            tests++; if (bus.stall !== 0 || bus.mf_data !== 0)
                begin fails++; $display("FAIL mt_%0d: stall %b mf %h want 0/0", i, bus.stall, bus.mf_data); end
            if (i % 2 == 0) mhi = v; else mlo = v;
            @(posedge clock); #1;
            drive(1'b1, (i % 2 == 0) ? MFHI : MFLO, $urandom, $urandom);
            #1;
            tests++; if (bus.stall !== 0 || bus.mf_data !== ((i % 2 == 0) ? mhi : mlo))
                begin fails++; $display("FAIL mf_%0d: stall %b mf %h want 0/%h", i, bus.stall, bus.mf_data, (i % 2 == 0) ? mhi : mlo); end
            tests++; if (bus.hi !== mhi || bus.lo !== mlo)
                begin fails++; $display("FAIL mt_regs_%0d: hi %h lo %h want %h %h", i, bus.hi, bus.lo, mhi, mlo); end
        end
        @(posedge clock); #1;
        drive(1'b0, MFHI, '0, '0);
        #1;
        tests++; if (bus.mf_data !== 0) begin fails++; $display("FAIL mf_novalid: got %h want 0", bus.mf_data); end
    endtask

    task automatic run_div(input string name, input logic [2:0] code, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit follow);
        logic [W-1:0] ehi, elo, edvd, edvs, old_lo;
        int cyc = 0, starts = 1;
        bit got = 0, stable = 1, stall_ok = 1;
        ref_div(code, a, b, ehi, elo, edvd, edvs);
        @(posedge clock); #1;
        old_lo = bus.lo;
        drive(1'b1, code, a, b);
        #1;
        tests++; if (bus.stall !== 0) begin fails++; $display("FAIL %s_accept: stall %b want 0", name, bus.stall); end
        @(posedge clock); #1;
        if (follow) drive(1'b1, MFLO, $urandom, $urandom);
        else        drive(1'b0, 3'b000, '0, '0);
        #1;
        tests++; if (bus.div_start !== 1) begin fails++; $display("FAIL %s_start: got %b want 1", name, bus.div_start); end
        tests++; if (bus.div_dividend !== edvd || bus.div_divisor !== edvs)
            begin fails++; $display("FAIL %s_operands: got %h/%h want %h/%h", name, bus.div_dividend, bus.div_divisor, edvd, edvs); end
        if (follow && bus.stall !== 1) stall_ok = 0;
        while (!got && cyc < 400) begin
            @(posedge clock); #2;
            cyc++;
            if (bus.div_start === 1'b1) starts++;
            if (bus.div_dividend !== edvd || bus.div_divisor !== edvs) stable = 0;
            if (follow && bus.stall !== 1) stall_ok = 0;
            got = bus.div_done;
        end
        tests++; if (!got) begin fails++; $display("FAIL %s_timeout: done %b after %0d cycles want 1", name, got, cyc); end
        tests++; if (starts != 1) begin fails++; $display("FAIL %s_start_pulse: got %0d strobes want 1", name, starts); end
        tests++; if (!stable) begin fails++; $display("FAIL %s_stable: operands changed, want %h/%h", name, edvd, edvs); end
        tests++; if (!stall_ok) begin fails++; $display("FAIL %s_stall_wait: stall dropped want 1", name); end
        @(posedge clock); #2;
        if (follow) begin
            tests++; if (bus.stall !== 1) begin fails++; $display("FAIL %s_stall_fix: got %b want 1", name, bus.stall); end
        end
        if (old_lo !== elo) begin
            tests++; if (bus.lo !== old_lo) begin fails++; $display("FAIL %s_early: lo %h want %h", name, bus.lo, old_lo); end
        end
        @(posedge clock); #2;
        tests++; if (bus.lo !== elo) begin fails++; $display("FAIL %s_lo: got %h want %h", name, bus.lo, elo); end
        tests++; if (bus.hi !== ehi) begin fails++; $display("FAIL %s_hi: got %h want %h", name, bus.hi, ehi); end
        if (follow) begin
            tests++; if (bus.stall !== 0 || bus.mf_data !== elo)
                begin fails++; $display("FAIL %s_mflo: stall %b mf %h want 0/%h", name, bus.stall, bus.mf_data, elo); end
        end
        drive(1'b0, 3'b000, '0, '0);
    endtask

    task automatic test_divide;
        core_lat = 32;
        run_div("divu_100_7", DIVU, 32'd100, 32'd7, 1'b0);
        run_div("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div("div_follow", DIV, 32'd1000, 32'hFFFF_FFFD, 1'b1);
    endtask

    task automatic test_random_div;
        logic [W-1:0] a, b;
        for (int i = 0; i < 10; i++) begin
            core_lat = $urandom_range(1, 12);
            a = ($urandom_range(0, 1) == 1) ? $urandom : -$urandom_range(0, 500);
            case ($urandom_range(0, 2))
                0:       b = $urandom_range(1, 20);
                1:       b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            if (b == 0) b = 32'd3;
            run_div($sformatf("rand%0d", i), ($urandom_range(0, 1) == 1) ? DIV : DIVU, a, b, $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_div_zero(input logic [2:0] code, input logic [W-1:0] a);
        @(posedge clock); #1;
        drive(1'b1, code, a, '0);
        #1;
        tests++; if (bus.stall !== 0 || bus.dz_pulse !== 0)
            begin fails++; $display("FAIL dz_pre: stall %b dz %b want 0/0", bus.stall, bus.dz_pulse); end
        @(posedge clock); #1;
        drive(1'b1, MFHI, $urandom, $urandom);
        #1;
        tests++; if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== a)
            begin fails++; $display("FAIL dz_result: hi %h lo %h want %h ffffffff", bus.hi, bus.lo, a); end
        tests++; if (bus.dz_pulse !== 1 || bus.div_start !== 0)
            begin fails++; $display("FAIL dz_pulse: dz %b start %b want 1/0", bus.dz_pulse, bus.div_start); end
        tests++; if (bus.stall !== 0 || bus.mf_data !== a)
            begin fails++; $display("FAIL dz_mfhi: stall %b mf %h want 0/%h", bus.stall, bus.mf_data, a); end
        @(posedge clock); #1;
        drive(1'b0, 3'b000, '0, '0);
        #1;
        tests++; if (bus.dz_pulse !== 0 || bus.div_start !== 0 || bus.hi !== a)
            begin fails++; $display("FAIL dz_after: dz %b start %b hi %h want 0/0/%h", bus.dz_pulse, bus.div_start, bus.hi, a); end
    endtask

    task automatic test_noop_stall;
        int cyc = 0;
        bit got = 0;
        core_lat = 10;
        @(posedge clock); #1;
        drive(1'b1, DIVU, 32'd1000, 32'd10);
        @(posedge clock); #1;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, c[2:0], $urandom, $urandom);
            #1;
            tests++; if (bus.stall !== (c != 0 && c != 7))
                begin fails++; $display("FAIL busy_stall_op%0d: got %b want %b", c, bus.stall, (c != 0 && c != 7)); end
            @(posedge clock); #1;
        end
        drive(1'b0, 3'b000, '0, '0);
        while (!got && cyc < 100) begin
            #1; got = bus.div_done;
            @(posedge clock); #1;
            cyc++;
        end
        repeat (2) @(posedge clock);
        #2;
        tests++; if (bus.lo !== 32'd100 || bus.hi !== 0)
            begin fails++; $display("FAIL busy_result: hi %h lo %h want 0 64", bus.hi, bus.lo); end
    endtask

    task automatic test_reset_wait;
        core_lat = 32;
        @(posedge clock); #1; drive(1'b1, MTHI, 32'hAAAA_AAAA, '0);
        @(posedge clock); #1; drive(1'b1, MTLO, 32'h5555_5555, '0);
        @(posedge clock); #1; drive(1'b1, DIVU, 32'd1000, 32'd3);
        @(posedge clock); #1; drive(1'b1, MFHI, '0, '0);
        repeat (5) @(posedge clock);
        #2;
        tests++; if (bus.stall !== 1) begin fails++; $display("FAIL rst_wait_stall: got %b want 1", bus.stall); end
        reset = 1'b1;
        #1;
        tests++; if (bus.hi !== 0 || bus.lo !== 0) begin fails++; $display("FAIL rst_wait_regs: hi %h lo %h want 0 0", bus.hi, bus.lo); end
        tests++; if (bus.stall !== 0 || bus.div_start !== 0)
            begin fails++; $display("FAIL rst_wait_ctrl: stall %b start %b want 0/0", bus.stall, bus.div_start); end
        @(posedge clock); #1;
        reset = 1'b0;
        drive(1'b0, 3'b000, '0, '0);
        repeat (40) @(posedge clock);
        #2;
        tests++; if (bus.hi !== 0 || bus.lo !== 0) begin fails++; $display("FAIL rst_late_done: hi %h lo %h want 0 0", bus.hi, bus.lo); end
        drive(1'b1, MFLO, '0, '0);
        #1;
        tests++; if (bus.stall !== 0 || bus.mf_data !== 0)
            begin fails++; $display("FAIL rst_idle: stall %b mf %h want 0/0", bus.stall, bus.mf_data); end
        // Reset during the start strobe must drop it before the core can see it.
        @(posedge clock); #1; drive(1'b1, DIV, 32'hFFFF_FFF8, 32'd2);
        @(posedge clock); #1; drive(1'b0, 3'b000, '0, '0);
        #1;
        tests++; if (bus.div_start !== 1) begin fails++; $display("FAIL rst_issue_pre: start %b want 1", bus.div_start); end
        reset = 1'b1;
        #1;
        tests++; if (bus.div_start !== 0 || bus.div_dividend !== 0)
            begin fails++; $display("FAIL rst_issue_async: start %b dvd %h want 0/0", bus.div_start, bus.div_dividend); end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (40) @(posedge clock);
        #2;
        tests++; if (bus.hi !== 0 || bus.lo !== 0 || bus.div_start !== 0)
            begin fails++; $display("FAIL rst_issue_after: hi %h lo %h start %b want 0 0 0", bus.hi, bus.lo, bus.div_start); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_divide();
        test_div_zero(DIVU, 32'd55);
        test_back_to_back();
        test_div_zero(DIV, 32'hFFFF_FF00);
        test_random_div();
        test_noop_stall();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
